// File: rtl/ps2_event_ctrl.sv
// PS/2 scan-code event controller: pops keyboard FIFO bytes, folds E0/F0 prefixes into key events.
// Optional typematic repeat filter enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_event_ctrl #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kb_ready,
  input  logic [7:0]         kb_data,
  input  logic               kb_overflow,
  output logic               kb_nextdata_n,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_break,
  output logic               evt_ext,
  output logic [COUNT_W-1:0] press_count,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DECODE,
    EMIT
  } state_t;

  state_t     state;
  logic [7:0] byte_q;
  logic       ext_q;
  logic       brk_q;
  logic       drop;

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] last_q;
  logic       last_vld;

  // a press equal to the last accepted press is a typematic repeat
  assign drop = !brk_q && last_vld && (last_q == {ext_q, byte_q});
`else
  assign drop = 1'b0;
`endif

  assign kb_nextdata_n = (state != POP);
  assign evt_valid     = (state == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      evt_code    <= 8'h00;
      evt_break   <= 1'b0;
      evt_ext     <= 1'b0;
      press_count <= '0;
      err         <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
      last_q      <= 9'h000;
      last_vld    <= 1'b0;
`endif
    end else begin
      if (kb_overflow) err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (kb_ready) state <= POP;
        end
        POP: begin
          byte_q <= kb_data;
          state  <= DECODE;
        end
        DECODE: begin
          state <= IDLE;
          if (byte_q == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (byte_q == 8'hF0) begin
            brk_q <= 1'b1;
          end else if (byte_q == 8'h00 || byte_q == 8'hFF || drop) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end else begin
            evt_code  <= byte_q;
            evt_ext   <= ext_q;
            evt_break <= brk_q;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (evt_ready) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            state <= IDLE;
            if (!evt_break) press_count <= press_count + COUNT_W'(1);
`ifdef PS2_REPEAT_FILTER_EN
            if (!evt_break) begin
              last_q   <= {evt_ext, evt_code};
              last_vld <= 1'b1;
            end else if (last_q == {evt_ext, evt_code}) begin
              last_vld <= 1'b0;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_event_ctrl.sv
// Directed bench for ps2_event_ctrl with a byte FIFO model and event log.
// Expected values follow PS2_REPEAT_FILTER_EN when it is defined.
module tb_ps2_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       kb_overflow = 1'b0;
  logic       kb_nextdata_n;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic [7:0] press_count;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:2047];
  int wr = 0;
  int rd = 0;
  int lows = 0;
  logic pop_pending = 1'b0;
  logic [9:0] evq [$];

  ps2_event_ctrl #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .kb_ready(kb_ready), .kb_data(kb_data),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
    .press_count(press_count), .err(err)
  );

  always #5 clk = ~clk;

  assign kb_ready = (wr != rd);
  assign kb_data  = mem[rd];

  always @(negedge clk) begin
    pop_pending <= !kb_nextdata_n;
    if (!kb_nextdata_n) lows <= lows + 1;
  end

  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready)
      evq.push_back({evt_ext, evt_break, evt_code});
    #1;
    if (pop_pending && rd != wr) rd <= rd + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr = wr + 1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (wr == rd && !evt_valid && kb_nextdata_n) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL drain_timeout: cycles=%0d budget=%0d", n, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({kb_nextdata_n, evt_valid, evt_code, evt_break, evt_ext, press_count, err}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: nd=%b v=%b code=%h b=%b e=%b cnt=%h err=%b",
               kb_nextdata_n, evt_valid, evt_code, evt_break, evt_ext, press_count, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_press();
    int e0 = evq.size();
    int r0 = rd;
    int l0 = lows;
    push(8'h1C);
    drain(50);
    checks++;
    if (evq.size() - e0 !== 1 || evq[e0] !== {1'b0, 1'b0, 8'h1C}) begin
      errors++;
      $display("FAIL press_event: n=%0d ev=%h want 1 event 01c", evq.size() - e0, evq[e0]);
    end
    checks++;
    if (press_count !== 8'd1) begin
      errors++;
      $display("FAIL press_count: got %0d want 1", press_count);
    end
    checks++;
    if (rd - r0 !== 1 || lows - l0 !== 1) begin
      errors++;
      $display("FAIL press_pop: pops=%0d low_cycles=%0d want 1/1", rd - r0, lows - l0);
    end
  endtask

  task automatic test_ext_break();
    int e0 = evq.size();
    int r0 = rd;
    push(8'hE0); push(8'hF0); push(8'h75);
    drain(80);
    checks++;
    if (evq.size() - e0 !== 1 || evq[e0] !== {1'b1, 1'b1, 8'h75}) begin
      errors++;
      $display("FAIL ext_break_event: n=%0d ev=%h want 1 event 375", evq.size() - e0, evq[e0]);
    end
    checks++;
    if (press_count !== 8'd1 || rd - r0 !== 3) begin
      errors++;
      $display("FAIL ext_break_count: cnt=%0d pops=%0d want 1/3", press_count, rd - r0);
    end
    e0 = evq.size();
    push(8'hF0); push(8'hE0); push(8'h75);
    drain(80);
    checks++;
    if (evq.size() - e0 !== 1 || evq[e0] !== {1'b1, 1'b1, 8'h75}) begin
      errors++;
      $display("FAIL break_ext_order: n=%0d ev=%h want 1 event 375", evq.size() - e0, evq[e0]);
    end
  endtask

  task automatic test_error_code();
    int e0;
    rst_pulse();
    e0 = evq.size();
    push(8'hE0); push(8'h00); push(8'hF0); push(8'hFF); push(8'h1C);
    drain(120);
    checks++;
    if (evq.size() - e0 !== 1 || evq[e0] !== {1'b0, 1'b0, 8'h1C} || press_count !== 8'd1) begin
      errors++;
      $display("FAIL error_code_discard: n=%0d ev=%h cnt=%0d want 1 event 01c cnt 1",
               evq.size() - e0, evq[e0], press_count);
    end
  endtask

  task automatic test_repeat();
    int e0;
    int want_n;
    logic [7:0] want_cnt;
`ifdef PS2_REPEAT_FILTER_EN
    want_n = 2; want_cnt = 8'd1;
`else
    want_n = 4; want_cnt = 8'd3;
`endif
    rst_pulse();
    e0 = evq.size();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain(150);
    checks++;
    if (evq.size() - e0 !== want_n || evq[e0] !== {1'b0, 1'b0, 8'h1C}
        || evq[evq.size() - 1] !== {1'b0, 1'b1, 8'h1C}) begin
      errors++;
      $display("FAIL repeat_events: n=%0d first=%h last=%h want %0d 01c..11c",
               evq.size() - e0, evq[e0], evq[evq.size() - 1], want_n);
    end
    checks++;
    if (press_count !== want_cnt) begin
      errors++;
      $display("FAIL repeat_count: got %0d want %0d", press_count, want_cnt);
    end
  endtask

  task automatic test_hold();
    int n = 0;
    int r0;
    logic [9:0] c0;
    rst_pulse();
    evt_ready = 1'b0;
    push(8'h1C); push(8'h2B);
    while (!evt_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!evt_valid) begin
      errors++;
      $display("FAIL hold_wait_valid: valid=%b after %0d cycles", evt_valid, n);
    end
    r0 = rd;
    c0 = {evt_ext, evt_break, evt_code};
    checks++;
    if (c0 !== {1'b0, 1'b0, 8'h1C}) begin
      errors++;
      $display("FAIL hold_event: got %h want 01c", c0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (!evt_valid || {evt_ext, evt_break, evt_code} !== c0 || rd !== r0 || !kb_nextdata_n) begin
        errors++;
        $display("FAIL hold_stable[%0d]: v=%b ev=%h pops=%0d nd=%b",
                 i, evt_valid, {evt_ext, evt_break, evt_code}, rd - r0, kb_nextdata_n);
      end
    end
    evt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL hold_accept: v=%b cnt=%0d want 0/1", evt_valid, press_count);
    end
    drain(60);
    checks++;
    if (press_count !== 8'd2) begin
      errors++;
      $display("FAIL hold_count: got %0d want 2", press_count);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    push(8'hF0);
    drain(40);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (press_count !== 8'd0 || evt_valid !== 1'b0 || kb_nextdata_n !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d v=%b nd=%b want 0/0/1", press_count, evt_valid, kb_nextdata_n);
    end
    @(negedge clk);
    rst = 1'b0;
    e0 = evq.size();
    push(8'h2B);
    drain(40);
    checks++;
    if (evq.size() - e0 !== 1 || evq[e0] !== {1'b0, 1'b0, 8'h2B} || press_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_event: n=%0d ev=%h cnt=%0d want 1 event 02b cnt 1",
               evq.size() - e0, evq[e0], press_count);
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_initial: got %b want 0", err);
    end
    @(negedge clk);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b want 1", err);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    rst_pulse();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got %b want 0", err);
    end
  endtask

  task automatic test_wrap();
    int e0;
    logic [7:0] b;
    rst_pulse();
    e0 = evq.size();
    for (int i = 0; i < 256; i++) begin
      b = (i % 2 == 0) ? 8'h1C : 8'h2B;
      push(b);
    end
    drain(3000);
    checks++;
    if (evq.size() - e0 !== 256 || press_count !== 8'h00) begin
      errors++;
      $display("FAIL count_wrap: n=%0d cnt=%h want 256 events cnt 00", evq.size() - e0, press_count);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_ext_break();
    test_error_code();
    test_repeat();
    test_hold();
    test_reset_mid();
    test_overflow();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_event_ctrl.md
PS2_EVENT_CTRL -- requirements
Module: ps2_event_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 8, width of the press counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port kb_ready  input  1  keyboard receive FIFO holds at least one byte.
REQ-005 SHALL have port kb_data  input  8  FIFO head byte, valid while kb_ready=1.
REQ-006 SHALL have port kb_overflow  input  1  keyboard FIFO overflow flag.
REQ-007 SHALL have port kb_nextdata_n  output  1  active-low FIFO pop strobe.
REQ-008 SHALL have port evt_valid  output  1  key event available.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-010 SHALL have port evt_code  output  8  scan code of event, excluding prefixes.
REQ-011 SHALL have port evt_break  output  1  1 = key release (F0-prefixed), 0 = press.
REQ-012 SHALL have port evt_ext  output  1  1 = E0-prefixed extended key.
REQ-013 SHALL have port press_count  output  COUNT_W  count of accepted press events.
REQ-014 SHALL have port err  output  1  sticky error: FIFO overflow seen.

Function
REQ-015 SHALL implement FSM states IDLE, POP, DECODE, EMIT; all outputs registered or decoded from state only.
REQ-016 IDLE: kb_ready=1 -> POP; otherwise remain in IDLE.
REQ-017 POP: kb_nextdata_n=0 for exactly this one cycle; kb_data is captured into a byte register; next state DECODE. kb_nextdata_n=1 in every other state.
REQ-018 DECODE with byte 0xE0: set the ext flag and return to IDLE; repeated E0 leaves ext set.
REQ-019 DECODE with byte 0xF0: set the brk flag and return to IDLE; E0 and F0 in either order both stay set.
REQ-020 DECODE with byte 0x00 or 0xFF (device error codes): discard the byte, clear the ext and brk flags, and return to IDLE with no event.
REQ-021 DECODE with any other byte: load evt_code, evt_ext=ext flag and evt_break=brk flag, then go to EMIT.
REQ-022 EMIT: evt_valid=1 and evt_code/evt_ext/evt_break held stable until evt_ready=1; on that cycle clear the ext and brk flags and go to IDLE.
REQ-023 Latency: kb_ready rising in cycle N with a plain code gives evt_valid=1 in cycle N+3 (minimum); the next pop happens no earlier than the cycle after acceptance.
REQ-024 press_count SHALL increment by 1 on each accepted event with evt_break=0, wrapping modulo 2^COUNT_W; release events do not count.
REQ-025 err SHALL set on any cycle with kb_overflow=1, remain set until reset, and not alter FSM operation.
REQ-026 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-027 rst=1 SHALL immediately, independent of clk, force state IDLE, kb_nextdata_n=1, evt_valid=0, evt_code=0x00, evt_break=0, evt_ext=0, press_count=0, err=0, and clear the ext, brk and filter registers.
REQ-028 Reset asserted mid-sequence (e.g. after E0/F0, or in EMIT) SHALL discard the pending prefix or event; no event is emitted after release.

Configuration
REQ-029 Macro PS2_REPEAT_FILTER_EN defined: the block SHALL keep the last emitted press {ext,code} and drop typematic repeats, i.e. a press identical to the last press with no intervening release of that key; dropped repeats return to IDLE without EMIT and do not count. A matching release clears the record.
REQ-030 Macro PS2_REPEAT_FILTER_EN undefined: every press SHALL be emitted and counted, and no filter register exists.

Verification
REQ-031 FIFO bytes 1C, evt_ready=1 -> one event with code=1C, break=0, ext=0; press_count=1; kb_nextdata_n low exactly 1 cycle.
REQ-032 Bytes E0 F0 75 -> one event with code=75, break=1, ext=1; press_count unchanged; 3 pops.
REQ-033 Bytes 1C 1C 1C F0 1C -> without the macro 4 events and press_count=3; with PS2_REPEAT_FILTER_EN 2 events (press, release) and press_count=1.
REQ-034 evt_ready held 0 for 10 cycles in EMIT -> evt_valid and outputs stable, no pop; evt_ready=1 -> accepted, IDLE next cycle.
REQ-035 Byte F0, then rst pulse, then byte 2B -> single press event code=2B, break=0; kb_overflow pulse -> err=1 until rst.
REQ-036 With COUNT_W=8, 256 press events -> press_count wraps to 0x00.
